// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issue/capture stage wrapped around a combinational single-precision FPU.
// Latency: the response is valid exactly SETTLE cycles after the accepting edge; throughput is one op per SETTLE+1 cycles.
// Backpressure: the response is held until rsp_ready; a new request is accepted only in IDLE or on the edge that retires a response.
module fpu_op_sequencer #(
  parameter int unsigned SETTLE = 2,   // cycles the FPU inputs settle before capture, 1..15
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  input  logic [31:0]      fpu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [1:0]       rsp_op,
  output logic [4:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  // The counter is loaded with SETTLE-1 so that capture lands SETTLE edges after accept.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [1:0] OP_DIV      = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic [3:0] settle_cnt_nxt;
  logic       accept;
  logic       capture;
  logic       retire;

  logic [7:0]  res_exp;
  logic [22:0] res_man;
  logic        a_zero;
  logic        a_nan;
  logic        b_zero;
  logic [4:0]  flags_nxt;

  // Classify the live FPU result; the operands are the registered ones, so this is stable during EXEC.
  always_comb begin
    res_exp   = fpu_result[30:23];
    res_man   = fpu_result[22:0];
    a_zero    = (fpu_a[30:0] == 31'd0);
    a_nan     = (fpu_a[30:23] == 8'hFF) && (fpu_a[22:0] != 23'd0);
    b_zero    = (fpu_b[30:0] == 31'd0);
    flags_nxt = {
      (fpu_op == OP_DIV) && b_zero && !a_zero && !a_nan,  // dz
      (res_exp == 8'hFF) && (res_man != 23'd0),           // nan
      (res_exp == 8'hFF) && (res_man == 23'd0),           // inf
      (res_exp == 8'h00) && (res_man == 23'd0),           // zero
      fpu_result[31]                                      // sign
    };
  end

  // Next-state, settle countdown and handshake strobes.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    req_ready      = 1'b0;
    accept         = 1'b0;
    capture        = 1'b0;
    retire         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
      end
      EXEC: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          settle_cnt_nxt = settle_cnt - 4'd1;
        end
      end
      DONE: begin
        // A retiring response frees the slot in the same cycle, so a waiting request may follow with no bubble.
        req_ready = rsp_ready;
        retire    = rsp_ready;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      req_ready = 1'b0;
    end
    accept = req_valid && req_ready;
    if (accept) begin
      state_nxt      = EXEC;
      settle_cnt_nxt = SETTLE_LOAD;
    end
  end

  // State and settle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // Operand registers change only on an accepting edge so the FPU output cannot glitch mid-capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_a  <= 32'd0;
      fpu_b  <= 32'd0;
      fpu_op <= 2'd0;
    end else if (accept) begin
      fpu_a  <= req_a;
      fpu_b  <= req_b;
      fpu_op <= req_op;
    end
  end

  // Response holding registers: loaded at the end of the settle window, released on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_op     <= 2'd0;
      rsp_flags  <= 5'd0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= fpu_result;
      rsp_op     <= fpu_op;
      rsp_flags  <= flags_nxt;
    end else if (retire) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Completed-response counter, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (retire) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE);

endmodule
